// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: CPU-priority arbiter for data-RAM port B with a host starvation guard
// and a host halt mode for bulk loading.
module dmem_port_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_ack,
  output logic [DW-1:0] host_rdata,
  input  logic          host_halt,
  output logic          halted,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_wen,
  input  logic [DW-1:0] mem_q
);
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_e;
  localparam logic [3:0] MW = 4'(MAX_WAIT);
  state_e state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic cpu_rvalid_q, host_ack_q, host_rd_q, halted_q;
  logic [DW-1:0] cpu_rdata_q, host_rdata_q;
  logic host_elig, host_gnt, cpu_gnt;
  // A host request still high in its ack cycle is stale and must not be granted again
  always_comb begin
    host_elig = host_req & ~host_ack_q;
    host_gnt  = state_q == RUN ? host_elig & (~cpu_req | wait_q == MW) : state_q == HALTED & host_elig;
    cpu_gnt   = state_q == RUN & cpu_req & ~host_gnt;
    state_d   = state_q == RUN ? (host_halt ? DRAIN : RUN) :
                state_q == DRAIN ? HALTED : (host_halt ? HALTED : RUN);
    wait_d    = (~host_req | host_gnt) ? 4'd0 :
                (state_q == RUN & host_elig & wait_q != MW) ? wait_q + 4'd1 : wait_q;
  end
  assign mem_addr   = host_gnt ? host_addr : cpu_gnt ? cpu_addr : '0;
  assign mem_wdata  = host_gnt ? host_wdata : cpu_gnt ? cpu_wdata : '0;
  assign mem_wen    = (host_gnt & host_we) | (cpu_gnt & cpu_we);
  assign cpu_stall  = (cpu_req & ~cpu_gnt) | (state_q != RUN);
  assign cpu_rvalid = cpu_rvalid_q;
  assign host_ack   = host_ack_q;
  assign halted     = halted_q;
  // RAM data arrives the cycle after the grant; the hold registers keep it afterwards
  assign cpu_rdata  = cpu_rvalid_q ? mem_q : cpu_rdata_q;
  assign host_rdata = (host_ack_q & host_rd_q) ? mem_q : host_rdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      wait_q       <= '0;
      cpu_rvalid_q <= 1'b0;
      host_ack_q   <= 1'b0;
      host_rd_q    <= 1'b0;
      halted_q     <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      host_ack_q   <= host_gnt;
      host_rd_q    <= host_gnt & ~host_we;
      halted_q     <= state_d == HALTED;
      cpu_rdata_q  <= cpu_rdata;
      host_rdata_q <= host_rdata;
    end
  end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: scoreboard bench with a 1-cycle-latency RAM model behind the arbiter.
module tb_dmem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cpu_req, cpu_we, host_req, host_we, host_halt;
  logic [AW-1:0] cpu_addr, host_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, host_wdata, cpu_rdata, host_rdata, mem_wdata, mem_q;
  logic cpu_stall, cpu_rvalid, host_ack, halted, mem_wen;
  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] cpu_q [$];
  logic [DW-1:0] host_q [$];
  int n_chk = 0;
  int n_pass = 0;

  dmem_port_arbiter #(.MAX_WAIT(4), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_halt(host_halt), .halted(halted),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen) ram[mem_addr[7:0]] <= mem_wdata;
    mem_q <= ram[mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic cpu(input logic r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_req = r; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic host(input logic r, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req = r; host_we = we; host_addr = a; host_wdata = d;
  endtask

  always @(negedge clk) begin
    if (rst_n && cpu_rvalid) begin
      if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", cpu_rvalid, 0);
      else check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    end
    if (rst_n && host_ack) begin
      if (host_q.size() == 0) check("host_ack_unexpected", host_ack, 0);
      else check("host_rdata", host_rdata, host_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cpu(0, 0, 0, 0);
    host(0, 0, 0, 0);
    host_halt = 0;
    repeat (2) @(negedge clk);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_halted", halted, 0);
    check("rst_mem_wen", mem_wen, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_cpu_stall", cpu_stall, 0);
    tick;
    rst_n = 1;
    tick;
    // CPU writes then reads back
    cpu(1, 1, 16'h0040, 16'h1234);
    @(negedge clk);
    check("cpu_wr_wen", mem_wen, 1);
    check("cpu_wr_addr", mem_addr, 16'h0040);
    check("cpu_wr_stall", cpu_stall, 0);
    tick;
    cpu(1, 1, 16'h0042, 16'h5678);
    tick;
    cpu(1, 0, 16'h0040, 0);
    cpu_q.push_back(16'h1234);
    @(negedge clk);
    check("cpu_rd_wen", mem_wen, 0);
    check("cpu_rd_stall", cpu_stall, 0);
    tick;
    cpu(0, 0, 0, 0);
    @(negedge clk);
    check("cpu_rd_rvalid", cpu_rvalid, 1);
    check("cpu_rd_stall2", cpu_stall, 0);
    tick;
    @(negedge clk);
    check("cpu_rvalid_pulse", cpu_rvalid, 0);
    check("cpu_rdata_hold", cpu_rdata, 16'h1234);
    tick;
    // Starvation: CPU requests every cycle, host forced through on the fifth
    host(1, 0, 16'h0040, 0);
    host_q.push_back(16'h1234);
    for (int i = 0; i < 4; i++) begin
      cpu(1, 0, 16'h0042, 0);
      cpu_q.push_back(16'h5678);
      @(negedge clk);
      check($sformatf("starve_cpu_addr%0d", i), mem_addr, 16'h0042);
      check($sformatf("starve_stall%0d", i), cpu_stall, 0);
      check($sformatf("starve_ack%0d", i), host_ack, 0);
      tick;
    end
    @(negedge clk);
    check("starve_host_addr", mem_addr, 16'h0040);
    check("starve_host_stall", cpu_stall, 1);
    tick;
    host(0, 0, 0, 0);
    cpu_q.push_back(16'h5678);
    @(negedge clk);
    check("starve_host_ack", host_ack, 1);
    check("starve_cpu_resume", cpu_stall, 0);
    tick;
    cpu(0, 0, 0, 0);
    tick;
    tick;
    // Host with idle CPU, request held through the ack cycle
    host(1, 0, 16'h0042, 0);
    host_q.push_back(16'h5678);
    @(negedge clk);
    check("idle_host_addr", mem_addr, 16'h0042);
    check("idle_host_ack0", host_ack, 0);
    tick;
    @(negedge clk);
    check("idle_host_ack1", host_ack, 1);
    check("idle_no_regrant_wen", mem_wen, 0);
    check("idle_no_regrant_addr", mem_addr, 0);
    tick;
    host(0, 0, 0, 0);
    @(negedge clk);
    check("idle_host_ack_pulse", host_ack, 0);
    tick;
    // Halt during a CPU read, host loads, then release
    cpu(1, 0, 16'h0040, 0);
    cpu_q.push_back(16'h1234);
    host_halt = 1;
    @(negedge clk);
    check("halt_cpu_granted", cpu_stall, 0);
    tick;
    cpu(0, 0, 0, 0);
    @(negedge clk);
    check("drain_rvalid", cpu_rvalid, 1);
    check("drain_stall", cpu_stall, 1);
    check("drain_halted", halted, 0);
    check("drain_wen", mem_wen, 0);
    tick;
    host(1, 1, 16'h0100, 16'hBEEF);
    host_q.push_back(16'h5678);
    @(negedge clk);
    check("halted_flag", halted, 1);
    check("halted_stall", cpu_stall, 1);
    check("halted_host_wen", mem_wen, 1);
    check("halted_host_addr", mem_addr, 16'h0100);
    tick;
    host(0, 0, 0, 0);
    host_halt = 0;
    @(negedge clk);
    check("halted_host_wr_ack", host_ack, 1);
    check("halted_stall2", cpu_stall, 1);
    tick;
    cpu(1, 0, 16'h0100, 0);
    cpu_q.push_back(16'hBEEF);
    @(negedge clk);
    check("resume_halted", halted, 0);
    check("resume_stall", cpu_stall, 0);
    tick;
    cpu(0, 0, 0, 0);
    tick;
    // Halt held for a single cycle
    host_halt = 1;
    @(negedge clk);
    check("abort_stall0", cpu_stall, 0);
    tick;
    host_halt = 0;
    @(negedge clk);
    check("abort_stall1", cpu_stall, 1);
    tick;
    @(negedge clk);
    check("abort_stall2", cpu_stall, 1);
    check("abort_halted", halted, 1);
    tick;
    @(negedge clk);
    check("abort_stall3", cpu_stall, 0);
    check("abort_halted_clr", halted, 0);
    tick;
    // Reset while a CPU read is in flight
    cpu(1, 0, 16'h0040, 0);
    @(negedge clk);
    rst_n = 0;
    cpu(0, 0, 0, 0);
    tick;
    check("midrst_rvalid", cpu_rvalid, 0);
    check("midrst_cpu_rdata", cpu_rdata, 0);
    check("midrst_host_rdata", host_rdata, 0);
    check("midrst_halted", halted, 0);
    rst_n = 1;
    tick;
    @(negedge clk);
    check("postrst_rvalid", cpu_rvalid, 0);
    check("postrst_wen", mem_wen, 0);
    check("postrst_stall", cpu_stall, 0);
    tick;
    check("cpu_q_empty", cpu_q.size(), 0);
    check("host_q_empty", host_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
